// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: runs mult/multu/div/divu over a fixed
// busy window, owns HI/LO, and serves mthi/mtlo/mfhi/mflo.
//
// Handshake: Start is a one-cycle combinational issue strobe (op 1-4 in E,
// unit idle, no exception, not in reset). Busy is registered and is high from
// the cycle after Start until the cycle in which the new HI/LO become visible.
// Ops presented while Busy are ignored; Req only suppresses the op in E.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  MDOp,
    input  logic [31:0] RS,
    input  logic [31:0] RT,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut,
    output logic [1:0]  md_state
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // S_RUN_NOWB: divide by zero, the busy window runs but HI/LO are kept.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_RUN_NOWB = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_q, busy_nxt;
    logic [31:0]      hi_q, hi_nxt, lo_q, lo_nxt;
    logic [31:0]      hi_tmp, hi_tmp_nxt, lo_tmp, lo_tmp_nxt;

    logic             is_md, is_div, div_signed, rt_zero;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      rs_mag, rt_mag, div_num, div_den;
    logic [31:0]      q_raw, r_raw, q_res, r_res;
    logic [31:0]      res_hi, res_lo;

    assign is_md      = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    assign is_div     = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
    assign div_signed = (MDOp == OP_DIV);
    assign rt_zero    = (RT == 32'd0);

    // Sign-extended operands keep the low 64 bits of the product exact.
    assign prod_s = {{32{RS[31]}}, RS} * {{32{RT[31]}}, RT};
    assign prod_u = {32'd0, RS} * {32'd0, RT};

    // One shared magnitude divider; signs restored afterwards so the quotient
    // truncates toward zero and the remainder follows the dividend.
    assign rs_mag  = RS[31] ? (~RS + 32'd1) : RS;
    assign rt_mag  = RT[31] ? (~RT + 32'd1) : RT;
    assign div_num = div_signed ? rs_mag : RS;
    assign div_den = rt_zero ? 32'd1 : (div_signed ? rt_mag : RT);
    assign q_raw   = div_num / div_den;
    assign r_raw   = div_num % div_den;

    always_comb begin
        q_res = q_raw;
        r_res = r_raw;
        if (div_signed) begin
            if (RS[31] ^ RT[31]) q_res = ~q_raw + 32'd1;
            if (RS[31])          r_res = ~r_raw + 32'd1;
        end
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (MDOp)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV,
            OP_DIVU:  {res_hi, res_lo} = {r_res, q_res};
            default:  {res_hi, res_lo} = 64'd0;
        endcase
    end

    assign Start = is_md && !busy_q && !Req && !reset;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        busy_nxt   = busy_q;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        hi_tmp_nxt = hi_tmp;
        lo_tmp_nxt = lo_tmp;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    hi_tmp_nxt = res_hi;
                    lo_tmp_nxt = res_lo;
                    cnt_nxt    = is_div ? DIV_LOAD : MULT_LOAD;
                    busy_nxt   = 1'b1;
                    state_nxt  = (is_div && rt_zero) ? S_RUN_NOWB : S_RUN;
                end else if (!Req && MDOp == OP_MTHI) begin
                    hi_nxt = RS;
                end else if (!Req && MDOp == OP_MTLO) begin
                    lo_nxt = RS;
                end
            end
            S_RUN, S_RUN_NOWB: begin
                if (cnt == CNT_ONE) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                    if (state == S_RUN) begin
                        hi_nxt = hi_tmp;
                        lo_nxt = lo_tmp;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            hi_tmp <= 32'd0;
            lo_tmp <= 32'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= busy_nxt;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
            hi_tmp <= hi_tmp_nxt;
            lo_tmp <= lo_tmp_nxt;
        end
    end

    assign Busy     = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_state = state;

    always_comb begin
        MDOut = 32'd0;
        if (MDOp == OP_MFHI)      MDOut = hi_q;
        else if (MDOp == OP_MFLO) MDOut = lo_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed scenarios plus randomized ops, all compared
// cycle by cycle against an arithmetic reference model of HI/LO and Busy.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        Req;
    logic [3:0]  MDOp;
    logic [31:0] RS, RT;
    logic        Start, Busy;
    logic [31:0] HI, LO, MDOut;
    logic [1:0]  md_state;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic        m_wb;
    logic [63:0] exp_q[$];

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Req(Req), .MDOp(MDOp), .RS(RS), .RT(RT),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut),
        .md_state(md_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    // One E-stage cycle: drive, check every output against the model, then
    // advance the model across the rising edge.
    task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic rq);
        logic        e_start;
        logic [31:0] e_md;
        logic [63:0] res;
        @(negedge clk);
        MDOp = op; RS = rs; RT = rt; Req = rq;
        #1;
        e_start = (op >= 4'd1 && op <= 4'd4) && (m_left == 0) && !rq;
        e_md    = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        check("start", {31'd0, Start}, {31'd0, e_start});
        check("busy",  {31'd0, Busy},  {31'd0, m_left > 0});
        check("hi",    HI,    m_hi);
        check("lo",    LO,    m_lo);
        check("mdout", MDOut, e_md);
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wb) begin
                res = exp_q.pop_front();
                {m_hi, m_lo} = res;
            end
        end else if (e_start) begin
            m_left = (op <= 4'd2) ? MC : DC;
            m_wb   = !(op >= 4'd3 && rt == 32'd0);
            if (m_wb) exp_q.push_back(ref_result(op, rs, rt));
        end else if (!rq && op == 4'd5) begin
            m_hi = rs;
        end else if (!rq && op == 4'd6) begin
            m_lo = rs;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // Sampled just after the edge that ended the previous step.
    task automatic expect_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        #1;
        check({tag, "_hi"}, HI, hi);
        check({tag, "_lo"}, LO, lo);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        MDOp = 4'd1; RS = 32'd7; RT = 32'd9; Req = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_busy",  {31'd0, Busy},  32'd0);
        check("rst_start", {31'd0, Start}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_wb = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        MDOp  = 4'd0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; MDOp = 4'd1; RS = 32'd3; RT = 32'd4; Req = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_wb = 1'b0;
        #12;
        check("por_start", {31'd0, Start}, 32'd0);
        check("por_busy",  {31'd0, Busy},  32'd0);
        check("por_hi", HI, 32'd0);
        check("por_lo", LO, 32'd0);
        MDOp = 4'd7;
        #1 check("por_mdout", MDOut, 32'd0);
        @(negedge clk);
        reset = 1'b0; MDOp = 4'd0;

        // mult -2 * 3
        step(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MC);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // multu 0xFFFFFFFF * 2, then mflo
        step(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MC);
        expect_hilo("multu", 32'd1, 32'hFFFF_FFFE);
        step(4'd8, 32'd0, 32'd0, 1'b0);

        // div / divu of -7 by 2, back to back
        step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DC);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        step(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DC);
        expect_hilo("divu", 32'd1, 32'h7FFF_FFFC);

        // overflow case of signed divide
        step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DC);
        expect_hilo("div_ovf", 32'd0, 32'h8000_0000);

        // divide by zero keeps HI/LO; a mult mid-busy is ignored
        step(4'd5, 32'h11, 32'd0, 1'b0);
        step(4'd6, 32'h22, 32'd0, 1'b0);
        step(4'd3, 32'd100, 32'd0, 1'b0);
        idle(3);
        step(4'd1, 32'd6, 32'd7, 1'b0);
        step(4'd5, 32'h99, 32'd0, 1'b0);
        idle(DC - 5);
        step(4'd0, 32'd0, 32'd0, 1'b0);
        expect_hilo("div0", 32'h11, 32'h22);

        // Req suppresses issue and mt writes
        step(4'd1, 32'd6, 32'd7, 1'b1);
        step(4'd5, 32'h5, 32'd0, 1'b1);
        step(4'd0, 32'd0, 32'd0, 1'b0);
        expect_hilo("req", 32'h11, 32'h22);

        // Req during an ongoing div does not cancel it
        step(4'd3, 32'd100, 32'd7, 1'b0);
        step(4'd7, 32'd0, 32'd0, 1'b1);
        step(4'd1, 32'd3, 32'd3, 1'b1);
        idle(DC - 2);
        expect_hilo("req_div", 32'd2, 32'd14);

        // reset in the third busy cycle of a mult, then mtlo
        step(4'd1, 32'd1234, 32'd5678, 1'b0);
        idle(2);
        reset_mid();
        step(4'd6, 32'hABCD, 32'd0, 1'b0);
        step(4'd0, 32'd0, 32'd0, 1'b0);
        expect_hilo("post_rst", 32'd0, 32'hABCD);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
            step(op, pick(), pick(), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) reset_mid();
        end
        idle(DC + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
